// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer.
// Holds the sequencer state encoding, the challenge width, the LFSR tap
// mask and the LFSR step function used by both the LFSR and the top.
// No ports (package).
package puf_pkg;

    localparam int CHAL_W = 8;

    // Feedback taps on bits 7, 5, 4 and 3 (maximal-length for 8 bits).
    localparam logic [CHAL_W-1:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        FIRE,
        RELEASE,
        OUT
    } state_t;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] l);
        return {l[CHAL_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator LFSR.
// Ports:
//   clk, rst     clock and synchronous active-high reset (reset -> SEED)
//   load         load load_value (a zero value is replaced by 1)
//   load_value   seed to load
//   step         advance one LFSR step
//   value        current LFSR contents
module puf_lfsr
    import puf_pkg::*;
#(
    parameter logic [CHAL_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CHAL_W-1:0] load_value,
    input  logic              step,
    output logic [CHAL_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            // All-zero is the lock-up state of an XOR LFSR.
            value <= (load_value == '0) ? CHAL_W'(1) : load_value;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Initiator side of an arbiter-PUF challenge/response interface.
// Drives LFSR challenges with timed race pulses, majority-votes REPEAT
// evaluations per challenge, packs WORD_BITS voted bits per word and hands
// the word plus an instability mask out over valid/ready.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, run                one-word start (IDLE only) / continuous mode
//   seed_load, seed           LFSR seed load (IDLE only, 0 -> 1)
//   puf_challenge, puf_pulse  challenge and race pulse to the PUF
//   puf_response              PUF response bit
//   resp_word, resp_unstable  packed voted bits / non-unanimous mask
//   resp_valid, resp_ready    output handshake
//   busy                      high whenever not IDLE
//
// state   | meaning
// IDLE    | waiting for start, seed may be loaded
// APPLY   | new challenge presented, pulse low (1 cycle)
// FIRE    | pulse high for SETTLE cycles, response sampled on last edge
// RELEASE | pulse low for SETTLE cycles, then re-fire or resolve the bit
// OUT     | word presented until accepted
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int                WORD_BITS = 8,
    parameter int                REPEAT    = 3,
    parameter int                SETTLE    = 4,
    parameter logic [CHAL_W-1:0] LFSR_SEED = 8'h01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 run,
    input  logic                 seed_load,
    input  logic [CHAL_W-1:0]    seed,
    output logic [CHAL_W-1:0]    puf_challenge,
    output logic                 puf_pulse,
    input  logic                 puf_response,
    output logic [WORD_BITS-1:0] resp_word,
    output logic [WORD_BITS-1:0] resp_unstable,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int EW = $clog2(REPEAT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = $clog2(WORD_BITS + 1);

    localparam logic [EW-1:0] REPEAT_C    = EW'(REPEAT);
    localparam logic [EW:0]   REPEAT_X    = (EW + 1)'(REPEAT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [BW-1:0] WORD_LAST   = BW'(WORD_BITS - 1);

    state_t                 state;
    logic [SW-1:0]          settle_cnt;
    logic [EW-1:0]          eval_cnt;
    logic [EW-1:0]          ones_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [WORD_BITS-1:0]   word_sh;
    logic [WORD_BITS-1:0]   unst_sh;

    logic [CHAL_W-1:0]      lfsr_value;
    logic                   lfsr_load;
    logic                   resolve;
    logic                   voted;
    logic                   unstable;
    logic [EW:0]            twice_ones;

    assign lfsr_load  = (state == IDLE) && seed_load;
    assign resolve    = (state == RELEASE) && (settle_cnt == '0) && (eval_cnt == REPEAT_C);
    assign twice_ones = {ones_cnt, 1'b0};
    assign voted      = twice_ones > REPEAT_X;
    assign unstable   = (ones_cnt != '0) && (ones_cnt != REPEAT_C);

    puf_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsr_load),
        .load_value(seed),
        .step      (resolve),
        .value     (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            eval_cnt      <= '0;
            ones_cnt      <= '0;
            bit_cnt       <= '0;
            word_sh       <= '0;
            unst_sh       <= '0;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            resp_word     <= '0;
            resp_unstable <= '0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!seed_load && start) begin
                        state         <= APPLY;
                        puf_challenge <= lfsr_value;
                        busy          <= 1'b1;
                    end
                end

                APPLY: begin
                    state      <= FIRE;
                    puf_pulse  <= 1'b1;
                    settle_cnt <= SETTLE_LAST;
                end

                FIRE: begin
                    if (settle_cnt == '0) begin
                        ones_cnt   <= ones_cnt + EW'(puf_response);
                        eval_cnt   <= eval_cnt + 1'b1;
                        puf_pulse  <= 1'b0;
                        settle_cnt <= SETTLE_LAST;
                        state      <= RELEASE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                RELEASE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (eval_cnt != REPEAT_C) begin
                        puf_pulse  <= 1'b1;
                        settle_cnt <= SETTLE_LAST;
                        state      <= FIRE;
                    end else begin
                        ones_cnt <= '0;
                        eval_cnt <= '0;
                        word_sh  <= {word_sh[WORD_BITS-2:0], voted};
                        unst_sh  <= {unst_sh[WORD_BITS-2:0], unstable};
                        if (bit_cnt == WORD_LAST) begin
                            bit_cnt       <= '0;
                            resp_word     <= {word_sh[WORD_BITS-2:0], voted};
                            resp_unstable <= {unst_sh[WORD_BITS-2:0], unstable};
                            state         <= OUT;
                        end else begin
                            bit_cnt       <= bit_cnt + 1'b1;
                            // The LFSR steps on this same edge, so present its successor.
                            puf_challenge <= lfsr_next(lfsr_value);
                            state         <= APPLY;
                        end
                    end
                end

                OUT: begin
                    // valid rises one cycle after the word is latched
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (run) begin
                            puf_challenge <= lfsr_value;
                            state         <= APPLY;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

    localparam int WB = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       run = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic       puf_response = 1'b0;
    logic [7:0] resp_word;
    logic [7:0] resp_unstable;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    puf_challenge_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .run          (run),
        .seed_load    (seed_load),
        .seed         (seed),
        .puf_challenge(puf_challenge),
        .puf_pulse    (puf_pulse),
        .puf_response (puf_response),
        .resp_word    (resp_word),
        .resp_unstable(resp_unstable),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // PUF model: a response is chosen at each pulse rise and logged with its challenge.
    bit         rand_mode = 1'b0;
    bit         flip_en = 1'b0;
    logic [7:0] flip_chal = 8'h04;
    int         flip_eval = 2;
    logic [7:0] last_chal = 8'h00;
    int         eval_n = 0;
    logic [7:0] chal_q[$];
    bit         resp_q[$];

    always @(posedge puf_pulse) begin
        logic r;
        if (puf_challenge !== last_chal) eval_n = 1;
        else eval_n = eval_n + 1;
        last_chal = puf_challenge;
        r = rand_mode ? 1'($urandom_range(0, 1)) : ^puf_challenge;
        if (flip_en && puf_challenge == flip_chal && eval_n == flip_eval) r = ~r;
        puf_response = r;
        chal_q.push_back(puf_challenge);
        resp_q.push_back(r);
    end

    int         rd_idx = 0;
    int         busy_low = 0;
    logic [7:0] model_next;
    logic [7:0] model_word;
    logic [7:0] model_unst;

    function automatic logic [7:0] step8(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Majority vote over the logged evaluations of one word.
    task automatic check_word(input string name, input logic [7:0] first);
        logic [7:0] l;
        logic [7:0] ew;
        logic [7:0] eu;
        int         ones;
        bit         chal_ok;
        l = first; ew = 8'h00; eu = 8'h00; chal_ok = 1'b1;
        if (chal_q.size() < rd_idx + WB * RP) begin
            n_cmp++; n_err++;
            $display("FAIL %s eval_count: saw %0d, need %0d", name, chal_q.size() - rd_idx, WB * RP);
            rd_idx = chal_q.size();
            model_next = first;
            return;
        end
        for (int b = 0; b < WB; b++) begin
            ones = 0;
            for (int e = 0; e < RP; e++) begin
                if (chal_q[rd_idx] !== l) chal_ok = 1'b0;
                ones += int'(resp_q[rd_idx]);
                rd_idx++;
            end
            ew = {ew[6:0], 1'(2 * ones > RP)};
            eu = {eu[6:0], 1'(ones != 0 && ones != RP)};
            l = step8(l);
        end
        model_next = l;
        model_word = ew;
        model_unst = eu;
        n_cmp++;
        if (!chal_ok) begin
            n_err++;
            $display("FAIL %s challenge_seq: observed sequence differs from LFSR from %h", name, first);
        end
        n_cmp++;
        if (resp_word !== ew) begin
            n_err++;
            $display("FAIL %s resp_word: got %h, want %h", name, resp_word, ew);
        end
        n_cmp++;
        if (resp_unstable !== eu) begin
            n_err++;
            $display("FAIL %s resp_unstable: got %h, want %h", name, resp_unstable, eu);
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (!busy) busy_low++;
            if (resp_valid) return;
        end
        n_cmp++; n_err++;
        $display("FAIL %s valid_timeout: resp_valid %b after %0d cycles, want 1", name, resp_valid, n);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic seed_and_start(input logic [7:0] s);
        seed = s; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        do_start();
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if ({puf_challenge, puf_pulse, resp_word, resp_unstable, resp_valid, busy} !== '0) begin
            n_err++;
            $display("FAIL %s outputs: chal=%h pulse=%b word=%h unst=%h valid=%b busy=%b, want all 0",
                     name, puf_challenge, puf_pulse, resp_word, resp_unstable, resp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        seed_and_start(8'h01);
        n_cmp++;
        if (puf_challenge !== 8'h01) begin
            n_err++; $display("FAIL basic first_chal: got %h, want 01", puf_challenge);
        end
        wait_valid("basic", n);
        n_cmp++;
        if (n !== 201) begin
            n_err++; $display("FAIL basic latency: got %0d, want 201", n);
        end
        check_word("basic", 8'h01);
        n_cmp++;
        if (resp_word !== 8'hF4 || resp_unstable !== 8'h00) begin
            n_err++; $display("FAIL basic known_word: got %h/%h, want F4/00", resp_word, resp_unstable);
        end
        accept();
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic after_accept: valid=%b busy=%b, want 0/0", resp_valid, busy);
        end
    endtask

    task automatic test_flip();
        int n;
        flip_en = 1'b1;
        seed_and_start(8'h01);
        wait_valid("flip", n);
        check_word("flip", 8'h01);
        n_cmp++;
        if (resp_word !== 8'hF4 || resp_unstable !== 8'h20) begin
            n_err++; $display("FAIL flip known_word: got %h/%h, want F4/20", resp_word, resp_unstable);
        end
        accept();
        flip_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        run = 1'b1; resp_ready = 1'b1; busy_low = 0;
        seed_and_start(8'h01);
        wait_valid("run1", n);
        check_word("run1", 8'h01);
        rand_mode = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (puf_challenge !== 8'h1C || busy !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL run next_word: chal=%h busy=%b valid=%b, want 1C/1/0", puf_challenge, busy, resp_valid);
        end
        wait_valid("run2", n);
        n_cmp++;
        if (busy_low !== 0) begin
            n_err++; $display("FAIL run busy_gap: busy low %0d cycles, want 0", busy_low);
        end
        check_word("run2", model_next);
        run = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL run stop: busy=%b, want 0", busy);
        end
        rand_mode = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        int held_bad;
        rand_mode = 1'b1;
        seed_and_start(8'h01);
        wait_valid("stall", n);
        check_word("stall", 8'h01);
        held_bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_word !== model_word || resp_unstable !== model_unst) held_bad++;
        end
        start = 1'b0;
        n_cmp++;
        if (held_bad !== 0) begin
            n_err++; $display("FAIL stall hold: %0d cycles changed, want 0 (last %b %h %h)",
                              held_bad, resp_valid, resp_word, resp_unstable);
        end
        accept();
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL stall to_idle: busy=%b valid=%b, want 0/0", busy, resp_valid);
        end
        rand_mode = 1'b0;
    endtask

    task automatic test_seed();
        int n;
        seed_and_start(8'h00);
        n_cmp++;
        if (puf_challenge !== 8'h01) begin
            n_err++; $display("FAIL seed zero_fix: got %h, want 01", puf_challenge);
        end
        repeat (3) @(posedge clk);
        #1; seed = 8'hAA; seed_load = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1; seed_load = 1'b0; start = 1'b0;
        wait_valid("seed_busy", n);
        check_word("seed_busy", 8'h01);
        accept();
        do_start();
        n_cmp++;
        if (puf_challenge !== model_next) begin
            n_err++; $display("FAIL seed continue: got %h, want %h", puf_challenge, model_next);
        end
        wait_valid("seed_cont", n);
        check_word("seed_cont", model_next);
        accept();
    endtask

    task automatic test_reset_mid();
        int         n;
        logic [7:0] target;
        bit         found;
        seed_and_start(8'h5A);
        target = step8(step8(step8(8'h5A)));
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (puf_challenge === target && puf_pulse === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL rst_mid reach_fire: challenge %h never fired, want %h", target, target);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        rd_idx = chal_q.size();
        do_start();
        n_cmp++;
        if (puf_challenge !== 8'h01) begin
            n_err++; $display("FAIL rst_mid reseed: got %h, want 01", puf_challenge);
        end
        wait_valid("rst_mid", n);
        check_word("rst_mid", 8'h01);
        n_cmp++;
        if (resp_word !== 8'hF4) begin
            n_err++; $display("FAIL rst_mid known_word: got %h, want F4", resp_word);
        end
        accept();
    endtask

    task automatic test_random();
        int         n;
        logic [7:0] s;
        logic [7:0] first;
        rand_mode = 1'b1;
        s = 8'($urandom_range(0, 255));
        first = (s == 8'h00) ? 8'h01 : s;
        run = 1'b1;
        seed_and_start(s);
        for (int w = 0; w < 4; w++) begin
            wait_valid("random", n);
            check_word("random", first);
            first = model_next;
            if (w == 3) run = 1'b0;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            accept();
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL random end_idle: busy=%b, want 0", busy);
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_back_to_back();
        test_stall();
        test_seed();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
